// File: rtl/hex_led_scan_ctrl_if.sv
// Display-value write port: two requesters, each with a valid/ready handshake.
interface hex_led_scan_ctrl_if;
   logic [31:0] req0_data;
   logic        req0_valid;
   logic        req0_ready;
   logic [31:0] req1_data;
   logic        req1_valid;
   logic        req1_ready;

   modport master (
      output req0_data, req0_valid, req1_data, req1_valid,
      input  req0_ready, req1_ready
   );

   modport slave (
      input  req0_data, req0_valid, req1_data, req1_valid,
      output req0_ready, req1_ready
   );
endinterface

// File: rtl/hex_led_scan_ctrl.sv
// 8-digit multiplexed 7-segment driver with round-robin arbitration of two writers.
// Optional HEX_LED_ZERO_BLANK_EN enables leading-zero suppression on digits 1..7.
module hex_led_scan_ctrl #(
   parameter int SCAN_DIV       = 50000,
   parameter int BLANK_CYC      = 500,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   hex_led_scan_ctrl_if.slave   req,
   output logic [31:0]          shown_data,
   output logic                 owner,
   output logic [7:0]           seg,
   output logic [7:0]           dig
);

   localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
   localparam int CW      = $clog2(CNT_MAX);
   localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
   // XOR mask that maps active-high internal levels onto pin polarity
   localparam logic [7:0] PIN_MASK = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

   typedef enum logic {ST_BLANK, ST_SHOW} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    idx, idx_nxt;
   logic          last_grant;
   logic          grant0, grant1;
   logic [3:0]    nibble;
   logic [7:0]    seg_raw, dig_raw;

   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'h0: decode = 7'h3F;  4'h1: decode = 7'h06;
         4'h2: decode = 7'h5B;  4'h3: decode = 7'h4F;
         4'h4: decode = 7'h66;  4'h5: decode = 7'h6D;
         4'h6: decode = 7'h7D;  4'h7: decode = 7'h07;
         4'h8: decode = 7'h7F;  4'h9: decode = 7'h6F;
         4'hA: decode = 7'h77;  4'hB: decode = 7'h7C;
         4'hC: decode = 7'h39;  4'hD: decode = 7'h5E;
         4'hE: decode = 7'h79;  default: decode = 7'h71;
      endcase
   endfunction

   // On contention the requester that did not win last time is served
   always_comb begin
      grant0 = req.req0_valid && (!req.req1_valid || last_grant);
      grant1 = req.req1_valid && (!req.req0_valid || !last_grant);
   end

   assign req.req0_ready = grant0;
   assign req.req1_ready = grant1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shown_data <= '0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
      end else if (grant0) begin
         shown_data <= req.req0_data;
         owner      <= 1'b0;
         last_grant <= 1'b0;
      end else if (grant1) begin
         shown_data <= req.req1_data;
         owner      <= 1'b1;
         last_grant <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_BLANK;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      idx_nxt   = idx;
      seg_raw   = '0;
      dig_raw   = '0;
      nibble    = shown_data[{idx, 2'b00} +: 4];
      case (state)
         ST_BLANK: begin
            if (cnt == BLANK_LAST) begin
               state_nxt = ST_SHOW;
               cnt_nxt   = '0;
            end
         end
         default: begin
            dig_raw = 8'd1 << idx;
            seg_raw = {1'b0, decode(nibble)};
`ifdef HEX_LED_ZERO_BLANK_EN
            // Digit 0 always shows so a zero value still displays "0"
            if (idx != 3'd0 && (shown_data >> {idx, 2'b00}) == 32'd0)
               seg_raw = '0;
`endif
            if (cnt == SHOW_LAST) begin
               state_nxt = ST_BLANK;
               cnt_nxt   = '0;
               idx_nxt   = idx + 3'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seg <= PIN_MASK;
         dig <= PIN_MASK;
      end else begin
         seg <= seg_raw ^ PIN_MASK;
         dig <= dig_raw ^ PIN_MASK;
      end
   end

endmodule

// File: tb/tb_hex_led_scan_ctrl.sv
// Scoreboard bench: driver pushes expected grants/values, a negedge monitor compares pins.
module tb_hex_led_scan_ctrl;
   localparam int SD  = 4;
   localparam int BC  = 2;
   localparam int PER = SD + BC;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   hex_led_scan_ctrl_if bus0();
   hex_led_scan_ctrl_if bus1();

   assign bus1.req0_data  = bus0.req0_data;
   assign bus1.req0_valid = bus0.req0_valid;
   assign bus1.req1_data  = bus0.req1_data;
   assign bus1.req1_valid = bus0.req1_valid;

   logic [31:0] sh0, sh1;
   logic        ow0, ow1;
   logic [7:0]  seg0, dig0, seg1, dig1;

   hex_led_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .SEG_ACTIVE_LOW(1'b0)) dut0 (
      .clk(clk), .reset(reset), .req(bus0),
      .shown_data(sh0), .owner(ow0), .seg(seg0), .dig(dig0));

   hex_led_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .SEG_ACTIVE_LOW(1'b1)) dut1 (
      .clk(clk), .reset(reset), .req(bus1),
      .shown_data(sh1), .owner(ow1), .seg(seg1), .dig(dig1));

   typedef struct {
      logic        r0;
      logic        r1;
      logic [31:0] sh;
      logic        ow;
   } exp_t;

   exp_t        exp_q[$];
   int          tests = 0;
   int          fails = 0;
   logic [7:0]  seg_tbl [16];

   bit          mon_en = 1'b0;
   int          mon_e;
   logic [31:0] sh_cur, sh_prev;
   logic        ow_cur;

   bit          p0, p1;
   logic [31:0] d0, d1;
   logic        mlast, mown;
   logic [31:0] mshown;
   int          ecount;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
      tests++;
      if (act !== req_v) begin
         fails++;
         $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, req_v, $time);
      end
   endtask

   // Expected active-high {dig,seg} while the scan has advanced e cycles past reset
   function automatic logic [15:0] scan_model(input int e, input logic [31:0] sh);
      int         p;
      int         d;
      logic [7:0] ds;
      logic [7:0] ss;
      p = e % PER;
      d = (e / PER) % 8;
      if (p < BC) return 16'h0000;
      ds = 8'd1 << d;
      ss = seg_tbl[sh[4*d +: 4]];
`ifdef HEX_LED_ZERO_BLANK_EN
      if (d > 0 && (sh >> (4*d)) == 32'd0) ss = 8'h00;
`endif
      return {ds, ss};
   endfunction

   initial begin
      exp_t        x;
      logic [15:0] pins;
      logic [7:0]  ed, es, nd, ns;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check("shown_data", sh0, sh_cur);
            check("owner", {31'd0, ow0}, {31'd0, ow_cur});
            check("shown_data_al", sh1, sh_cur);
            pins = (mon_e == 0) ? 16'h0000 : scan_model(mon_e - 1, sh_prev);
            ed = pins[15:8];
            es = pins[7:0];
            nd = ~ed;
            ns = ~es;
            check("dig", {24'd0, dig0}, {24'd0, ed});
            check("seg", {24'd0, seg0}, {24'd0, es});
            check("dig_al", {24'd0, dig1}, {24'd0, nd});
            check("seg_al", {24'd0, seg1}, {24'd0, ns});
            sh_prev = sh_cur;
            if (exp_q.size() > 0) begin
               x = exp_q.pop_front();
               check("req0_ready", {31'd0, bus0.req0_ready}, {31'd0, x.r0});
               check("req1_ready", {31'd0, bus0.req1_ready}, {31'd0, x.r1});
               check("req0_ready_al", {31'd0, bus1.req0_ready}, {31'd0, x.r0});
               check("req1_ready_al", {31'd0, bus1.req1_ready}, {31'd0, x.r1});
               sh_cur = x.sh;
               ow_cur = x.ow;
            end
            mon_e++;
         end
      end
   end

   task automatic reset_model();
      p0 = 1'b0;  p1 = 1'b0;
      mlast = 1'b1;  mshown = '0;  mown = 1'b0;
      ecount = 0;
      exp_q.delete();
      mon_e = 0;  sh_cur = '0;  sh_prev = '0;  ow_cur = 1'b0;
   endtask

   // One clock: present pending requests, predict the winner, advance past the edge
   task automatic step();
      exp_t x;
      int   win;
      bus0.req0_valid = p0;  bus0.req0_data = d0;
      bus0.req1_valid = p1;  bus0.req1_data = d1;
      if (p0 && p1)  win = mlast ? 0 : 1;
      else if (p0)   win = 0;
      else if (p1)   win = 1;
      else           win = -1;
      x.r0 = (win == 0);
      x.r1 = (win == 1);
      if (win >= 0) begin
         mshown = (win == 1) ? d1 : d0;
         mown   = (win == 1);
         mlast  = (win == 1);
         if (win == 0) p0 = 1'b0; else p1 = 1'b0;
      end
      x.sh = mshown;
      x.ow = mown;
      exp_q.push_back(x);
      @(posedge clk);
      #1;
      ecount++;
   endtask

   task automatic hold_value(input bit who, input logic [31:0] v, input int cycles);
      if (who) begin p1 = 1'b1; d1 = v; end
      else     begin p0 = 1'b1; d0 = v; end
      repeat (cycles) step();
   endtask

   initial begin
      seg_tbl = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                  8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
      d0 = '0;  d1 = '0;
      reset_model();
      bus0.req0_valid = 1'b0;  bus0.req1_valid = 1'b0;
      bus0.req0_data  = '0;    bus0.req1_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      mon_en = 1'b1;

      // Idle scan, one write from requester 1, then async reset while digit 5 is lit
      repeat (10) step();
      hold_value(1'b1, 32'hDEADBEEF, 1);
      while (ecount < 34) step();
      mon_en = 1'b0;
      bus0.req0_valid = 1'b0;
      bus0.req1_valid = 1'b0;
      #2;
      check("dig_digit5", {24'd0, dig0}, 32'h20);
      check("shown_before_reset", sh0, 32'hDEADBEEF);
      reset = 1'b0;
      #1;
      check("reset_seg", {24'd0, seg0}, 32'h00);
      check("reset_dig", {24'd0, dig0}, 32'h00);
      check("reset_seg_al", {24'd0, seg1}, 32'hFF);
      check("reset_dig_al", {24'd0, dig1}, 32'hFF);
      check("reset_shown", sh0, 32'h0);
      check("reset_owner", {31'd0, ow0}, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_model();
      reset = 1'b1;
      mon_en = 1'b1;

      // Both requesters continuously valid: grants must alternate starting with 0
      repeat (8) begin
         if (!p0) begin p0 = 1'b1; d0 = 32'h11111111; end
         if (!p1) begin p1 = 1'b1; d1 = 32'h22222222; end
         step();
      end
      p0 = 1'b0;  p1 = 1'b0;
      repeat (3) step();

      hold_value(1'b0, 32'h00000000, 52);
      hold_value(1'b0, 32'h1234ABCF, 52);
      hold_value(1'b1, 32'h00000008, 52);
      hold_value(1'b0, 32'h000000A5, 52);
      hold_value(1'b1, 32'hF0000000, 52);

      // Randomized sparse traffic with a bias toward values having leading zeros
      repeat (500) begin
         if (!p0 && $urandom_range(0, 11) == 0) begin
            p0 = 1'b1;  d0 = $urandom >> $urandom_range(0, 31);
         end
         if (!p1 && $urandom_range(0, 11) == 0) begin
            p1 = 1'b1;  d1 = $urandom >> $urandom_range(0, 31);
         end
         step();
      end
      p0 = 1'b0;  p1 = 1'b0;
      repeat (4) step();
      mon_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
